// File: rtl/cache_arbiter.sv
// Single-port line arbiter between the LC-3b I-cache and D-cache.
// Define CACHE_ARB_ROUND_ROBIN_EN for alternating tie-break; default gives D fixed priority.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_mem_read,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  output logic [LINE_WIDTH-1:0] i_mem_rdata,
  output logic                  i_mem_resp,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_wdata,
  output logic [LINE_WIDTH-1:0] d_mem_rdata,
  output logic                  d_mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SERVE_I = 2'd1;
  localparam logic [1:0] S_SERVE_D = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            op_q, op_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic i_req, d_req, tie_to_d, grant_d, grant_i;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  assign tie_to_d = ~last_d_q;

  always_comb begin
    last_d_d = last_d_q;
    if (grant_d)
      last_d_d = 1'b1;
    else if (grant_i)
      last_d_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_d_q <= 1'b1;
    else
      last_d_q <= last_d_d;
  end
`else
  assign tie_to_d = 1'b1;
`endif

  assign grant_d = (state_q == S_IDLE) & d_req
                 & (~i_req | tie_to_d);
  assign grant_i = (state_q == S_IDLE) & i_req & ~grant_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d = S_SERVE_D;
          addr_d  = d_mem_address;
          // Write wins when both D strobes are raised.
          op_d    = {~d_mem_write, d_mem_write};
          if (d_mem_write)
            wdata_d = d_mem_wdata;
        end else if (grant_i) begin
          state_d = S_SERVE_I;
          addr_d  = i_mem_address;
          op_d    = 2'b10;
        end
      end
      S_SERVE_I, S_SERVE_D: begin
        if (pmem_resp)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      op_q    <= 2'b00;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
    end
  end

  logic serving;
  assign serving = (state_q != S_IDLE);

  assign pmem_read    = serving & op_q[1];
  assign pmem_write   = serving & op_q[0];
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_mem_resp  = (state_q == S_SERVE_I) & pmem_resp;
  assign d_mem_resp  = (state_q == S_SERVE_D) & pmem_resp;
  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: vector table, directed corner sequences, random vs model.
// Honours CACHE_ARB_ROUND_ROBIN_EN for the expected tie-break.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_mem_read;
  logic [15:0]  i_mem_address;
  logic [127:0] i_mem_rdata;
  logic         i_mem_resp;
  logic         d_mem_read;
  logic         d_mem_write;
  logic [15:0]  d_mem_address;
  logic [127:0] d_mem_wdata;
  logic [127:0] d_mem_rdata;
  logic         d_mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk(clk),
    .reset(reset),
    .i_mem_read(i_mem_read),
    .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata),
    .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read),
    .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address),
    .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata),
    .d_mem_resp(d_mem_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        ir, dr, dw;
    logic [15:0] ia, da;
    logic        presp;
    logic        er, ew;
    logic [15:0] ea;
    logic        eir, edr;
  } vec_t;

  vec_t tbl[16];

  task automatic idle_inputs();
    i_mem_read    = 1'b0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    i_mem_address = 16'h0;
    d_mem_address = 16'h0;
    d_mem_wdata   = 128'h0;
    pmem_resp     = 1'b0;
    pmem_rdata    = 128'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference model
  logic         m_busy, m_d, m_rd, m_wr, m_last_d;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;

  task automatic model_edge();
    logic ir, dq, pick_d;
    if (m_busy) begin
      if (pmem_resp) m_busy = 1'b0;
    end else begin
      ir = i_mem_read;
      dq = d_mem_read | d_mem_write;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      pick_d = dq && (!ir || !m_last_d);
`else
      pick_d = dq;
`endif
      if (pick_d) begin
        m_busy = 1'b1; m_d = 1'b1; m_addr = d_mem_address;
        m_wr = d_mem_write; m_rd = !d_mem_write;
        if (d_mem_write) m_wdata = d_mem_wdata;
        m_last_d = 1'b1;
      end else if (ir) begin
        m_busy = 1'b1; m_d = 1'b0; m_addr = i_mem_address;
        m_rd = 1'b1; m_wr = 1'b0;
        m_last_d = 1'b0;
      end
    end
  endtask

  logic [127:0] bigw;
  logic         exp_side[3];

  initial begin
    tbl[0]  = '{1,0,0,16'h1230,16'h0000,0, 0,0,16'h0000,0,0};
    tbl[1]  = '{1,0,0,16'h1230,16'h0000,0, 1,0,16'h1230,0,0};
    tbl[2]  = '{1,0,0,16'h1230,16'h0000,0, 1,0,16'h1230,0,0};
    tbl[3]  = '{1,0,0,16'h1230,16'h0000,0, 1,0,16'h1230,0,0};
    tbl[4]  = '{1,0,0,16'h1230,16'h0000,1, 1,0,16'h1230,1,0};
    tbl[5]  = '{0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,0,0};
    tbl[6]  = '{0,0,0,16'h0000,16'h0000,1, 0,0,16'h0000,0,0};
    tbl[7]  = '{0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,0,0};
    tbl[8]  = '{0,1,0,16'h0000,16'h4440,0, 0,0,16'h0000,0,0};
    tbl[9]  = '{0,0,0,16'h0000,16'h0000,0, 1,0,16'h4440,0,0};
    tbl[10] = '{0,0,0,16'h0000,16'h0000,1, 1,0,16'h4440,0,1};
    tbl[11] = '{0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,0,0};
    tbl[12] = '{0,1,1,16'h0000,16'h2222,0, 0,0,16'h0000,0,0};
    tbl[13] = '{0,0,0,16'h0000,16'h0000,0, 0,1,16'h2222,0,0};
    tbl[14] = '{0,0,0,16'h0000,16'h0000,1, 0,1,16'h2222,0,1};
    tbl[15] = '{0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,0,0};

    // Reset state
    reset = 1'b1;
    idle_inputs();
    pmem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    #3;
    chk("rst_ctl", 128'({pmem_read, pmem_write, i_mem_resp, d_mem_resp}), 128'h0);
    chk("rst_addr", 128'(pmem_address), 128'h0);
    chk("rst_wdata", pmem_wdata, 128'h0);
    chk("rst_irdata", i_mem_rdata, pmem_rdata);
    chk("rst_drdata", d_mem_rdata, pmem_rdata);
    do_reset();

    // Vector table
    for (int i = 0; i < 16; i++) begin
      i_mem_read    = tbl[i].ir;
      d_mem_read    = tbl[i].dr;
      d_mem_write   = tbl[i].dw;
      i_mem_address = tbl[i].ia;
      d_mem_address = tbl[i].da;
      pmem_resp     = tbl[i].presp;
      pmem_rdata    = {4{$urandom}};
      if (tbl[i].dr && tbl[i].dw)
        $display("note: row %0d drives illegal D read+write", i);
      @(negedge clk);
      chk($sformatf("tbl%0d_ctl", i),
          128'({pmem_read, pmem_write, i_mem_resp, d_mem_resp}),
          128'({tbl[i].er, tbl[i].ew, tbl[i].eir, tbl[i].edr}));
      if (tbl[i].er || tbl[i].ew)
        chk($sformatf("tbl%0d_addr", i), 128'(pmem_address), 128'(tbl[i].ea));
      chk($sformatf("tbl%0d_rdata", i), i_mem_rdata, pmem_rdata);
      step();
    end

    // D write: wdata latched at grant
    do_reset();
    bigw = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    d_mem_write = 1'b1; d_mem_address = 16'h8000; d_mem_wdata = bigw;
    @(negedge clk);
    chk("dw_grantcyc", 128'(pmem_write), 128'h0);
    step();
    d_mem_write = 1'b0; d_mem_wdata = 128'h0; d_mem_address = 16'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("dw_strobe", 128'({pmem_write, pmem_read, d_mem_resp}), 128'h4);
      chk("dw_wdata", pmem_wdata, bigw);
      chk("dw_addr", 128'(pmem_address), 128'h8000);
      step();
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("dw_resp", 128'({d_mem_resp, i_mem_resp}), 128'h2);
    step();
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("dw_idle", 128'({pmem_write, d_mem_resp}), 128'h0);

    // Repeated ties
    do_reset();
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    exp_side = '{1'b0, 1'b1, 1'b0};
`else
    exp_side = '{1'b1, 1'b1, 1'b1};
`endif
    i_mem_read = 1'b1; i_mem_address = 16'h1000;
    d_mem_read = 1'b1; d_mem_address = 16'h2000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      step();
      pmem_resp = 1'b1;
      @(negedge clk);
      chk($sformatf("tie%0d_resp", k), 128'({d_mem_resp, i_mem_resp}),
          exp_side[k] ? 128'h2 : 128'h1);
      chk($sformatf("tie%0d_addr", k), 128'(pmem_address),
          exp_side[k] ? 128'h2000 : 128'h1000);
      step();
      pmem_resp = 1'b0;
    end
    i_mem_read = 1'b0; d_mem_read = 1'b0;

    // I request dropped mid-transaction
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 16'h0AB0;
    step();
    i_mem_read = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("drop_hold", 128'({pmem_read, i_mem_resp}), 128'h2);
      step();
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("drop_resp", 128'({pmem_read, i_mem_resp, d_mem_resp}), 128'h6);
    step();
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("drop_idle", 128'({pmem_read, i_mem_resp}), 128'h0);

    // Reset while serving D
    do_reset();
    d_mem_write = 1'b1; d_mem_address = 16'h3000; d_mem_wdata = 128'h55;
    step();
    d_mem_write = 1'b0;
    @(negedge clk);
    chk("rmid_busy", 128'(pmem_write), 128'h1);
    step();
    #1 reset = 1'b1;
    #1 chk("rmid_drop", 128'({pmem_write, pmem_read}), 128'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("rmid_noresp", 128'({d_mem_resp, i_mem_resp, pmem_write}), 128'h0);
    step();
    pmem_resp = 1'b0;
    i_mem_read = 1'b1; i_mem_address = 16'h5550;
    step();
    i_mem_read = 1'b0;
    @(negedge clk);
    chk("rmid_igrant", 128'({pmem_read, pmem_address}), 128'h1_5550);
    step();
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("rmid_iresp", 128'({i_mem_resp, d_mem_resp}), 128'h2);
    step();
    pmem_resp = 1'b0;

    // Random traffic against the model
    do_reset();
    m_busy = 1'b0; m_d = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
    m_last_d = 1'b1; m_addr = 16'h0; m_wdata = 128'h0;
    for (int c = 0; c < 600; c++) begin
      int r;
      r = int'($urandom_range(0, 3));
      i_mem_read    = $urandom_range(0, 1) == 1;
      d_mem_read    = (r == 1);
      d_mem_write   = (r == 2);
      i_mem_address = 16'($urandom);
      d_mem_address = 16'($urandom);
      d_mem_wdata   = {4{$urandom}};
      pmem_resp     = $urandom_range(0, 2) == 0;
      pmem_rdata    = {4{$urandom}};
      @(negedge clk);
      chk("rnd_ctl", 128'({pmem_read, pmem_write, i_mem_resp, d_mem_resp}),
          128'({m_busy && m_rd, m_busy && m_wr,
                m_busy && pmem_resp && !m_d,
                m_busy && pmem_resp && m_d}));
      if (m_busy)
        chk("rnd_addr", 128'(pmem_address), 128'(m_addr));
      if (m_busy && m_wr)
        chk("rnd_wdata", pmem_wdata, m_wdata);
      model_edge();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single physical-memory port between the LC-3b pipeline's instruction cache (read-only) and data cache (read/write). It sits between the two L1 cache controllers and physical memory. Each transaction is a full line, and the arbiter serialises transactions one at a time. The requester address, operation and write data are latched at grant, so pmem sees stable signals for the whole transaction regardless of upstream behaviour.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word)
- LINE_WIDTH, 128, cache line width in bits

Ports:
- clk  in  1  sole clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- i_mem_read  in  1  I-cache line read request, level, held until i_mem_resp
- i_mem_address  in  ADDR_WIDTH  I-cache request address
- i_mem_rdata  out  LINE_WIDTH  line data to I-cache
- i_mem_resp  out  1  one-cycle completion pulse to I-cache
- d_mem_read  in  1  D-cache line read request, level
- d_mem_write  in  1  D-cache line write (writeback) request, level
- d_mem_address  in  ADDR_WIDTH  D-cache request address
- d_mem_wdata  in  LINE_WIDTH  D-cache writeback data
- d_mem_rdata  out  LINE_WIDTH  line data to D-cache
- d_mem_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  physical memory read strobe
- pmem_write  out  1  physical memory write strobe
- pmem_address  out  ADDR_WIDTH  latched transaction address
- pmem_wdata  out  LINE_WIDTH  latched write data
- pmem_rdata  in  LINE_WIDTH  physical memory read data
- pmem_resp  in  1  physical memory completion, one cycle

## Operation
- States: s_idle, s_serve_i, s_serve_d.
- s_idle: evaluate requests each cycle.
  - D request only (d_mem_read|d_mem_write) -> s_serve_d.
  - I request only -> s_serve_i.
  - Both -> tie rule (see Configuration).
  - On the transition edge, latch: addr_reg <= granted address; op_reg <= {read, write}; wdata_reg <= d_mem_wdata (D writes only).
- D side with d_mem_read and d_mem_write both high: write wins, read dropped. This is an illegal input; the bench flags it but the RTL must stay deterministic.
- s_serve_i / s_serve_d:
  - pmem_read/pmem_write driven from op_reg; pmem_address = addr_reg; pmem_wdata = wdata_reg.
  - Wait for pmem_resp.
  - On pmem_resp: pulse the granted side's *_mem_resp in the same cycle (combinational) and go to s_idle next edge.
  - Upstream request changes during service are ignored.
- i_mem_rdata and d_mem_rdata are both tied to pmem_rdata. Only the resp pulse qualifies the data.
- pmem_resp in s_idle: ignored, no resp pulse.
- Outputs in s_idle: pmem_read=0, pmem_write=0, both resp=0.

## Timing
- Reset values:
  - state=s_idle, addr_reg=0, wdata_reg=0, op_reg=0.
  - last_grant=D (only when the macro is defined).
  - All strobes and resp outputs 0; rdata outputs follow pmem_rdata.
- Grant latency: request high in idle cycle N -> pmem strobe high in cycle N+1.
- Completion: pmem_resp in cycle M -> requester resp in cycle M -> s_idle at M+1.
- Minimum request-to-request spacing: one idle cycle between consecutive transactions.
- A requester still asserting in the cycle after its resp (at M+1) is treated as a new request. Caches must drop the request in the resp cycle's following edge.
- Reset mid-transaction: immediate return to s_idle, strobes drop asynchronously. The in-flight pmem_resp is ignored, and no resp is issued upstream.

## Configuration
- CACHE_ARB_ROUND_ROBIN_EN defined:
  - A last_grant register is updated at every grant.
  - On a tie in s_idle, the side not granted last wins.
  - After reset the first tie goes to I.
- Not defined:
  - Fixed priority; D wins every tie.
  - No last_grant register exists.

## Test plan
- Lone I read at 0x1230, pmem_resp 3 cycles after strobe:
  - pmem_read=1, pmem_address=0x1230 from cycle N+1.
  - i_mem_resp pulses exactly once with pmem_rdata; d_mem_resp stays 0.
- Lone D write to 0x8000 with wdata 0xDEAD…BEEF; d_mem_wdata changed to 0 after grant:
  - pmem_write=1, and pmem_wdata keeps 0xDEAD…BEEF until pmem_resp.
  - d_mem_resp then pulses.
- I and D read raised in the same idle cycle, held across three ties:
  - Without the macro: D, D, D granted, I starves.
  - With the macro: I, D, I.
- I request dropped mid-transaction (i_mem_read falls before pmem_resp):
  - pmem_read stays 1 until pmem_resp.
  - i_mem_resp still pulses; then s_idle.
- Reset asserted while in s_serve_d waiting on pmem_resp:
  - pmem_write=0 immediately.
  - The later pmem_resp produces no d_mem_resp; the next I request is granted normally.
- pmem_resp pulsed in s_idle with no requests: no resp outputs and state unchanged.
